mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on posedge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: req_valid  in  1  request present; req_ready  out  1  unit idle and accepting.
REQ-004 SHALL have ports: req_write  in  1  1=store, 0=load; req_addr  in  32  byte address; req_wdata  in  32  store data (right-aligned).
REQ-005 SHALL have ports: req_size  in  2  0=byte, 1=half, 2=word, 3=reserved; req_unsigned  in  1  zero-extend loads.
REQ-006 SHALL have ports: resp_valid  out  1; resp_ready  in  1; resp_rdata  out  32  extended load data (0 for stores); resp_err  out  1  misaligned or reserved size.
REQ-007 SHALL have memory-side ports: mem_addr  out  32; mem_din  out  32; mem_read  out  1; mem_write  out  1; mem_dout  in  32. The memory is word-addressed (addr>>2), reads combinationally and writes a full word on posedge when mem_write=1.

Function
REQ-008 SHALL implement states IDLE, RD, RMW_RD, WR, RESP.
REQ-009 SHALL assert req_ready only in IDLE; a request is accepted on a posedge with req_valid=1 in IDLE; all req_* fields are latched at acceptance.
REQ-010 SHALL flag error when req_size=3, or size=half with addr[0]=1, or size=word with addr[1:0]!=0; an error request goes IDLE->RESP with resp_err=1 and never asserts mem_read/mem_write.
REQ-011 SHALL route loads IDLE->RD->RESP: mem_read=1 in RD only; mem_dout captured at the end of RD; resp_valid first high 2 cycles after acceptance.
REQ-012 SHALL route word stores IDLE->WR->RESP: mem_write=1 in WR only, mem_din=latched wdata.
REQ-013 SHALL route byte/half stores IDLE->RMW_RD->WR->RESP: mem_read=1 in RMW_RD, captured word merged with the addressed lane(s) of wdata, merged word driven in WR; other lanes unchanged.
REQ-014 SHALL drive mem_addr = {latched addr[31:2], 2'b00} in RD, RMW_RD, WR; 0 otherwise.
REQ-015 SHALL extract loads little-endian: byte lane addr[1:0], half lane addr[1]; sign-extend unless req_unsigned=1; word loads pass unmodified.
REQ-016 SHALL hold resp_valid, resp_rdata, resp_err stable in RESP until resp_valid&resp_ready on a posedge, then return to IDLE; no new request accepted in that same cycle.
REQ-017 SHALL never assert mem_read and mem_write in the same cycle, and SHALL assert each for exactly one cycle per access.

Reset
REQ-018 SHALL, on posedge with reset=1, enter IDLE from any state, cancel any in-flight access without issuing a response, and clear latched request and response registers.
REQ-019 SHALL drive, in IDLE (including the first cycle after reset): req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_din=0.
REQ-020 SHALL, when reset is high during WR, still present mem_write=1 that cycle; the memory ignores writes under reset, so no store completes.

Structure
REQ-021 SHALL place the size encodings (BYTE/HALF/WORD/RSVD) and the state encoding in a shared package used by the CPU and the bench.
REQ-022 SHALL implement lane extraction/merge in one combinational sub-module mem_lane_align (inputs: word, addr[1:0], size, unsigned, wdata; outputs: load value, merged word).
REQ-023 SHALL contain no memory array; storage stays in the memory block.

Verification
REQ-024 Word store addr=0x10 data=0xDEADBEEF, then word load addr=0x10 -> mem_write one cycle at mem_addr 0x10, load resp_rdata=0xDEADBEEF 2 cycles after acceptance.
REQ-025 Memory word 0x11223344 at 0x20; byte store 0xAA to 0x21 -> RMW_RD then WR; word now 0x1122AA44; signed byte load 0x21 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
REQ-026 Half load addr=0x23 -> resp_err=1, no mem_read/mem_write pulse; req_size=3 at 0x20 -> resp_err=1.
REQ-027 Load completes, resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable for all 5, req_ready=0 until handshake.
REQ-028 Reset asserted during RMW_RD of a half store to 0x30 -> IDLE next cycle, no response, memory word at 0x30 unchanged.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// alignment rule used to reject illegal requests.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } mem_size_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WR     = 3'd3,
    ST_RESP   = 3'd4
  } mau_state_e;

  // Reserved size counts as an error alongside the natural-alignment cases.
  function automatic logic access_error(input logic [1:0] size, input logic [1:0] addr_lo);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = addr_lo[0];
      SZ_WORD: err = (addr_lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane handling: extracts/extends a load value from a memory word
// and merges store data into the addressed byte or half lane.
import mem_access_unit_pkg::*;

module mem_lane_align (
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v   = word_i[7:0];
    half_v   = addr_i[1] ? word_i[31:16] : word_i[15:0];
    load_o   = word_i;
    merged_o = word_i;
    case (addr_i)
      2'd0:    byte_v = word_i[7:0];
      2'd1:    byte_v = word_i[15:8];
      2'd2:    byte_v = word_i[23:16];
      default: byte_v = word_i[31:24];
    endcase
    case (size_i)
      SZ_BYTE: begin
        load_o = unsigned_i ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
        case (addr_i)
          2'd0:    merged_o[7:0]   = wdata_i[7:0];
          2'd1:    merged_o[15:8]  = wdata_i[7:0];
          2'd2:    merged_o[23:16] = wdata_i[7:0];
          default: merged_o[31:24] = wdata_i[7:0];
        endcase
      end
      SZ_HALF: begin
        load_o = unsigned_i ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
        if (addr_i[1]) merged_o[31:16] = wdata_i[15:0];
        else           merged_o[15:0]  = wdata_i[15:0];
      end
      default: begin
        load_o   = word_i;
        merged_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit between a CPU request/response port and a
// word-addressed memory; sub-word stores are done as read-modify-write.
import mem_access_unit_pkg::*;

module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout,
  output logic [2:0]  dbg_state
);

  // Handshakes: a transfer happens on a posedge where valid and ready are both
  // high; the unit holds resp_* stable while resp_valid=1 and resp_ready=0.

  mau_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        write_q, write_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] lane_load;
  logic [31:0] lane_merged;
  logic [31:0] word_addr;

  assign word_addr = {addr_q[31:2], 2'b00};
  assign dbg_state = state_q;

  mem_lane_align u_lane (
    .word_i     (mem_dout),
    .addr_i     (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .load_o     (lane_load),
    .merged_o   (lane_merged)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    uns_d      = uns_q;
    write_d    = write_q;
    word_d     = word_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'h0;
    resp_err   = 1'b0;
    mem_addr   = 32'h0;
    mem_din    = 32'h0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          uns_d   = req_unsigned;
          write_d = req_write;
          word_d  = 32'h0;
          rdata_d = 32'h0;
          err_d   = 1'b0;
          if (access_error(req_size, req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (!req_write)      state_d = ST_RD;
          else if (req_size == SZ_WORD) state_d = ST_WR;
          else                          state_d = ST_RMW_RD;
        end
      end
      ST_RD: begin
        mem_read = 1'b1;
        mem_addr = word_addr;
        rdata_d  = lane_load;
        state_d  = ST_RESP;
      end
      ST_RMW_RD: begin
        mem_read = 1'b1;
        mem_addr = word_addr;
        word_d   = lane_merged;
        state_d  = ST_WR;
      end
      ST_WR: begin
        mem_write = 1'b1;
        mem_addr  = word_addr;
        // Word stores skip the read, so the merged register is not used.
        mem_din   = (size_q == SZ_WORD) ? wdata_q : word_q;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = write_q ? 32'h0 : rdata_q;
        resp_err   = err_q;
        if (resp_ready) begin
          state_d = ST_IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      write_q <= 1'b0;
      word_q  <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      write_q <= write_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_read, mem_write;
  logic [2:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt, wr_cnt, both_cnt;
  logic [31:0] rd_addr, wr_addr;
  logic [31:0] exp_q[$];
  logic [31:0] mem [0:63];

  logic [31:0] rd;
  logic        er;
  int          lat;

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read),
    .mem_write(mem_write), .mem_dout(mem_dout), .dbg_state(dbg_state)
  );

  // clock / memory / monitor
  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_write && !reset) mem[mem_addr[7:2]] <= mem_din;
    if (mem_read)  begin rd_cnt <= rd_cnt + 1; rd_addr <= mem_addr; end
    if (mem_write) begin wr_cnt <= wr_cnt + 1; wr_addr <= mem_addr; end
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver: present one request; returns #1 after the accepting posedge
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic u);
    @(negedge clk);
    rd_cnt = 0; wr_cnt = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    req_size = sz; req_unsigned = u;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // full transaction; lat counts cycles from acceptance to first resp_valid
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] sz, input logic u, input int stall,
                     output logic [31:0] rdo, output logic ero, output int lato);
    int cyc;
    issue(w, a, d, sz, u);
    cyc = 1;
    while (!resp_valid && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    lato = cyc;
    rdo  = resp_rdata;
    ero  = resp_err;
    if (!resp_valid) check("resp_timeout", {31'h0, resp_valid}, 32'h1);
    for (int i = 0; i < stall; i++) begin
      check("stall_valid", {31'h0, resp_valid}, 32'h1);
      check("stall_rdata", resp_rdata, rdo);
      check("stall_req_ready", {31'h0, req_ready}, 32'h0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  // scoreboard path for loads
  task automatic load_chk(input string tag, input logic [31:0] a, input logic [1:0] sz,
                          input logic u, input logic [31:0] exp);
    logic [31:0] got;
    logic        e;
    int          l;
    exp_q.push_back(exp);
    txn(1'b0, a, 32'h0, sz, u, 0, got, e, l);
    check({tag, "_data"}, got, exp_q.pop_front());
    check({tag, "_lat"}, l, 32'd2);
    check({tag, "_err"}, {31'h0, e}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[8]  = 32'h11223344;
    mem[12] = 32'h55667788;
    mem[13] = 32'hCAFEF00D;
    rd_cnt = 0; wr_cnt = 0; both_cnt = 0; rd_addr = 0; wr_addr = 0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 0; req_wdata = 0;
    req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // reset state
    check("rst_state", {29'h0, dbg_state}, {29'h0, ST_IDLE});
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_rw", {30'h0, mem_read, mem_write}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_din", mem_din, 32'h0);

    // word store then word load
    txn(1'b1, 32'h10, 32'hDEADBEEF, SZ_WORD, 1'b0, 0, rd, er, lat);
    check("wst_lat", lat, 32'd2);
    check("wst_rdata", rd, 32'h0);
    check("wst_wr_cnt", wr_cnt, 32'd1);
    check("wst_rd_cnt", rd_cnt, 32'd0);
    check("wst_addr", wr_addr, 32'h10);
    check("wst_mem", mem[4], 32'hDEADBEEF);
    load_chk("wld", 32'h10, SZ_WORD, 1'b0, 32'hDEADBEEF);
    check("wld_rd_cnt", rd_cnt, 32'd1);
    check("wld_addr", rd_addr, 32'h10);

    // byte store via read-modify-write, upper bits of wdata ignored
    txn(1'b1, 32'h21, 32'h123456AA, SZ_BYTE, 1'b0, 0, rd, er, lat);
    check("bst_lat", lat, 32'd3);
    check("bst_rw_cnt", {rd_cnt[15:0], wr_cnt[15:0]}, {16'd1, 16'd1});
    check("bst_addr", wr_addr, 32'h20);
    check("bst_mem", mem[8], 32'h1122AA44);
    load_chk("bld_s", 32'h21, SZ_BYTE, 1'b0, 32'hFFFFFFAA);
    load_chk("bld_u", 32'h21, SZ_BYTE, 1'b1, 32'h000000AA);

    // half store to upper lane, then half/byte extraction variants
    txn(1'b1, 32'h22, 32'hFFFFBEEF, SZ_HALF, 1'b0, 0, rd, er, lat);
    check("hst_mem", mem[8], 32'hBEEFAA44);
    load_chk("hld_s_hi", 32'h22, SZ_HALF, 1'b0, 32'hFFFFBEEF);
    load_chk("hld_u_lo", 32'h20, SZ_HALF, 1'b1, 32'h0000AA44);
    load_chk("bld_s_l0", 32'h20, SZ_BYTE, 1'b0, 32'h00000044);
    load_chk("bld_u_l3", 32'h23, SZ_BYTE, 1'b1, 32'h000000BE);

    // errors: misaligned half, reserved size, misaligned word store
    txn(1'b0, 32'h23, 32'h0, SZ_HALF, 1'b0, 0, rd, er, lat);
    check("err_half_err", {31'h0, er}, 32'h1);
    check("err_half_lat", lat, 32'd1);
    check("err_half_rdata", rd, 32'h0);
    check("err_half_mem", {rd_cnt[15:0], wr_cnt[15:0]}, 32'h0);
    txn(1'b0, 32'h20, 32'h0, SZ_RSVD, 1'b0, 0, rd, er, lat);
    check("err_rsvd_err", {31'h0, er}, 32'h1);
    check("err_rsvd_mem", {rd_cnt[15:0], wr_cnt[15:0]}, 32'h0);
    txn(1'b1, 32'h26, 32'h99999999, SZ_WORD, 1'b0, 0, rd, er, lat);
    check("err_wst_err", {31'h0, er}, 32'h1);
    check("err_wst_mem", mem[9], 32'h0);

    // response back-pressure
    txn(1'b0, 32'h20, 32'h0, SZ_WORD, 1'b0, 5, rd, er, lat);
    check("stall_data", rd, 32'hBEEFAA44);
    check("stall_after_hs", {31'h0, resp_valid}, 32'h0);

    // reset during RMW_RD of a half store
    issue(1'b1, 32'h30, 32'h00001234, SZ_HALF, 1'b0);
    check("rmw_state", {29'h0, dbg_state}, {29'h0, ST_RMW_RD});
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rmw_rst_state", {29'h0, dbg_state}, {29'h0, ST_IDLE});
    check("rmw_rst_ready", {31'h0, req_ready}, 32'h1);
    repeat (3) begin
      @(posedge clk); #1;
      check("rmw_rst_no_resp", {31'h0, resp_valid}, 32'h0);
    end
    check("rmw_rst_mem", mem[12], 32'h55667788);

    // reset during WR: write strobe still visible, memory ignores it
    issue(1'b1, 32'h34, 32'h0BADF00D, SZ_WORD, 1'b0);
    reset = 1'b1;
    #1;
    check("wr_rst_strobe", {31'h0, mem_write}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    check("wr_rst_mem", mem[13], 32'hCAFEF00D);
    load_chk("post_rst_ld", 32'h30, SZ_WORD, 1'b0, 32'h55667788);

    check("rd_wr_overlap", both_cnt, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
